shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle shifter for the datapath. Applies a shift of 0..DATA_W-1 bits
//   by repeating a one-bit shift step, one step per clock.
//   The controller FSM drives it with a start/ready/done handshake.
//   The 2-bit shift op encoding matches the datapath shift field.
//   The result is registered and held until the next accepted operation.
// PARAMETERS
//   DATA_W  16  operand/result width
//   AMT_W   4   shift-amount width; must equal clog2(DATA_W)
// PORTS
//   clk    in   1       rising-edge clock
//   reset  in   1       synchronous, active-high reset
//   start  in   1       request; sampled only when ready=1
//   shift  in   2       00 pass, 01 left (0 fill), 10 logical right, 11 arith right
//   amt    in   AMT_W   number of bit positions to shift
//   bin    in   DATA_W  operand
//   ready  out  1       high in IDLE only; start accepted when ready&start
//   done   out  1       one-cycle pulse: out now holds the new result
//   out    out  DATA_W  registered result
// BEHAVIOUR
//   - Reset (sync, active-high, at a clk edge):
//       state=IDLE, out=0, done=0, ready=1, working reg=0, cnt=0.
//     Reset dominates start.
//   - States: IDLE, SHIFT, DONE.
//   - IDLE:
//       ready=1.
//       On start: latch work=bin, op=shift, cnt=(shift==00)?0:amt.
//       Next state: SHIFT if cnt!=0, else DONE.
//   - SHIFT:
//       ready=0.
//       Each cycle: work=step(work,op), cnt=cnt-1.
//       When the step with cnt==1 is taken, next state is DONE.
//   - DONE:
//       out=work (registered on entry), done=1 for exactly one cycle.
//       Next state: IDLE unconditionally.
//   - Latency: start sampled in cycle 0 -> done=1 in cycle amt+1
//     (cycle 1 when amt=0 or shift=00).
//     Next start is accepted in cycle amt+2 at the earliest.
//   - Step semantics:
//       01: work<<1
//       10: work>>1 (msb=0)
//       11: work>>1 with msb replicated
//   - Boundaries:
//       amt=DATA_W-1 with op 11 gives all sign bits.
//       amt=0 returns bin unchanged.
//   - out is stable from IDLE through SHIFT. It keeps the previous result
//     and changes only on entry to DONE.
//   - start while ready=0 is ignored: no queuing and no effect on the
//     operation in flight. bin/shift/amt are don't-care after acceptance.
//   - Reset mid-operation aborts with no done pulse.
//     Outputs return to reset values on the next edge.
// STRUCTURE
//   - Package shift_pkg:
//       localparams SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11.
//       State encodings S_IDLE, S_SHIFT, S_DONE.
//   - Sub-module shift_step: combinational one-bit step (op, in) -> out.
//     It is instantiated once on the working register.
//   - Top level: FSM, cnt down-counter, working register, out register.
// TESTING
//   1. Hold reset 2 cycles, then release -> ready=1, done=0, out=16'h0000.
//   2. bin=16'h8001, shift=01, amt=3 -> done in cycle 4, out=16'h0008.
//   3. bin=16'h8000, amt=15:
//        shift=11 -> done in cycle 16, out=16'hFFFF.
//        shift=10 -> out=16'h0001.
//   4. bin=16'h1234:
//        shift=10, amt=0 -> done in cycle 1, out=16'h1234.
//        shift=00, amt=7 -> done in cycle 1, out=16'h1234.
//   5. Pulse start during SHIFT with new operands -> ignored, first result
//      unchanged. Then issue start the cycle ready returns -> accepted,
//      done at the expected cycle.
//   6. Start with amt=8, assert reset in cycle 3 -> next cycle ready=1,
//      out=0; no done pulse over the following 10 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: shift op field values
// and controller state encodings.
package shift_pkg;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift step.
// Ports: op (shift op), din (operand), dout (operand shifted by one bit).
module shift_step
    import shift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        unique case (op)
            SH_LSL:  dout = {din[W-2:0], 1'b0};
            SH_LSR:  dout = {1'b0, din[W-1:1]};
            SH_ASR:  dout = {din[W-1], din[W-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock, start/ready/done handshake.
// Ports: clk, reset (sync, high), start, shift, amt, bin -> ready, done, out.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        shift,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] bin,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] out
);

    state_t state, state_nxt;

    logic [DATA_W-1:0] work, work_nxt;
    logic [DATA_W-1:0] step_out;
    logic [1:0]        op, op_nxt;
    logic [AMT_W-1:0]  cnt, cnt_nxt;
    logic              out_ld;

    shift_step #(.W(DATA_W)) u_step (
        .op   (op),
        .din  (work),
        .dout (step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            work  <= '0;
            op    <= SH_NONE;
            cnt   <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
            if (out_ld) begin
                out <= work_nxt;
            end
        end
    end

    // out is loaded on the same edge that enters DONE, so it holds the
    // previous result through IDLE and SHIFT.
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        op_nxt    = op;
        cnt_nxt   = cnt;
        out_ld    = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    work_nxt = bin;
                    op_nxt   = shift;
                    cnt_nxt  = (shift == SH_NONE) ? '0 : amt;
                    if (cnt_nxt == '0) begin
                        state_nxt = S_DONE;
                        out_ld    = 1'b1;
                    end else begin
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_nxt = step_out;
                cnt_nxt  = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_nxt = S_DONE;
                    out_ld    = 1'b1;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
